// File: rtl/serialtopar.sv
// serialtopar: serial-to-parallel lane receiver.
// Hunts for the idle comma to find byte alignment. It locks after BC_LOCK
// consecutive aligned commas, then strobes one byte every 8 bit-clock edges.
// Optional feature macro: SERIALTOPAR_BYTECNT_EN adds a saturating 16-bit
// count of valid payload bytes on the byte_count output.
module serialtopar #(
  parameter logic [7:0]  COMMA   = 8'hBC,
  parameter int unsigned BC_LOCK = 4
) (
  input  logic        clk_8f,
  input  logic        reset,
  input  logic        data_in,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        byte_stb,
  output logic        active
`ifdef SERIALTOPAR_BYTECNT_EN
  ,
  output logic [15:0] byte_count
`endif
);

  typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(BC_LOCK);

  state_t      state, state_nxt;
  // Only the 7 most recent bits are needed: together with data_in they form
  // the byte that completes on the current edge.
  logic [6:0]  shift_q;
  logic [2:0]  cnt, cnt_nxt;
  logic [3:0]  bc_cnt, bc_cnt_nxt;
  logic [7:0]  nxt;
  logic        boundary;
  logic        load;

  assign nxt      = {shift_q, data_in};
  assign boundary = (cnt == 3'd7);

  // Next-state logic: comma hunt, aligned comma counting, and byte loading.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bc_cnt_nxt = bc_cnt;
    load       = 1'b0;
    unique case (state)
      HUNT: begin
        cnt_nxt = 3'd0;
        if (nxt == COMMA) begin
          bc_cnt_nxt = 4'd1;
          state_nxt  = (LOCK_N == 4'd1) ? LOCKED : ALIGN;
        end
      end
      ALIGN: begin
        cnt_nxt = cnt + 3'd1;
        if (boundary) begin
          if (nxt == COMMA) begin
            if ((bc_cnt + 4'd1) >= LOCK_N) begin
              bc_cnt_nxt = LOCK_N;
              state_nxt  = LOCKED;
            end else begin
              bc_cnt_nxt = bc_cnt + 4'd1;
            end
          end else begin
            // Comma was not on a real byte boundary: discard alignment.
            bc_cnt_nxt = 4'd0;
            cnt_nxt    = 3'd0;
            state_nxt  = HUNT;
          end
        end
      end
      LOCKED: begin
        cnt_nxt = cnt + 3'd1;
        load    = boundary;
      end
      default: begin
        state_nxt  = HUNT;
        cnt_nxt    = 3'd0;
        bc_cnt_nxt = 4'd0;
      end
    endcase
  end

  // State, shift register and counters; active follows the state being entered.
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      state   <= HUNT;
      shift_q <= '0;
      cnt     <= '0;
      bc_cnt  <= '0;
      active  <= 1'b0;
    end else begin
      state   <= state_nxt;
      shift_q <= nxt[6:0];
      cnt     <= cnt_nxt;
      bc_cnt  <= bc_cnt_nxt;
      active  <= (state_nxt == LOCKED);
    end
  end

  // Byte outputs: load on each locked boundary, hold otherwise; strobe one cycle.
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      byte_stb  <= 1'b0;
    end else begin
      byte_stb <= load;
      if (load) begin
        data_out  <= nxt;
        valid_out <= (nxt != COMMA);
      end
    end
  end

`ifdef SERIALTOPAR_BYTECNT_EN
  // Saturating count of valid payload bytes since reset.
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      byte_count <= 16'h0000;
    end else if (load && (nxt != COMMA) && (byte_count != 16'hFFFF)) begin
      byte_count <= byte_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_serialtopar.sv
// tb_serialtopar: directed scenarios with randomized payload, checked every
// edge against a bit-history reference model of the receiver.
module tb_serialtopar;

  localparam logic [7:0] BC   = 8'hBC;
  localparam int         LOCK = 4;
  localparam int         M_HUNT = 0, M_ALIGN = 1, M_LOCKED = 2;

  logic        clk_8f  = 1'b0;
  logic        reset   = 1'b1;
  logic        data_in = 1'b0;
  logic [7:0]  data_out;
  logic        valid_out, byte_stb, active;
`ifdef SERIALTOPAR_BYTECNT_EN
  logic [15:0] byte_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: full bit history since reset plus alignment bookkeeping.
  bit         hist[$];
  int         mode, anchor, run, e_cnt;
  logic [7:0] e_data;
  logic       e_valid, e_stb, e_active;

  always #5 clk_8f = ~clk_8f;

  serialtopar #(.COMMA(BC), .BC_LOCK(LOCK)) dut (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .byte_stb  (byte_stb),
    .active    (active)
`ifdef SERIALTOPAR_BYTECNT_EN
    ,
    .byte_count(byte_count)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // The byte formed by the last 8 received bits (bits before reset read as 0).
  function automatic logic [7:0] last_byte();
    logic [7:0] v;
    int idx;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      idx = hist.size() - 8 + i;
      v[7 - i] = (idx >= 0) ? hist[idx] : 1'b0;
    end
    return v;
  endfunction

  task automatic model_reset();
    hist.delete();
    mode = M_HUNT; anchor = 0; run = 0; e_cnt = 0;
    e_data = 8'h00; e_valid = 1'b0; e_stb = 1'b0; e_active = 1'b0;
  endtask

  // Apply the receive rules for the edge that just consumed the newest bit.
  task automatic model_edge();
    int t;
    logic [7:0] v;
    bit on_boundary;
    t = hist.size() - 1;
    v = last_byte();
    on_boundary = (t != anchor) && (((t - anchor) % 8) == 0);
    e_stb = 1'b0;
    if (mode == M_HUNT) begin
      if (v == BC) begin
        anchor = t;
        run    = 1;
        mode   = (LOCK == 1) ? M_LOCKED : M_ALIGN;
      end
    end else if (mode == M_ALIGN) begin
      if (on_boundary) begin
        if (v == BC) begin
          run++;
          if (run >= LOCK) mode = M_LOCKED;
        end else begin
          mode = M_HUNT;
          run  = 0;
        end
      end
    end else if (on_boundary) begin
      e_data  = v;
      e_valid = (v != BC);
      e_stb   = 1'b1;
      if (e_valid && e_cnt < 65535) e_cnt++;
    end
    e_active = (mode == M_LOCKED);
  endtask

  task automatic step(input bit b);
    @(negedge clk_8f);
    data_in = b;
    @(posedge clk_8f);
    #1;
    hist.push_back(b);
    model_edge();
    check("data_out",  16'(data_out),  16'(e_data));
    check("valid_out", 16'(valid_out), 16'(e_valid));
    check("byte_stb",  16'(byte_stb),  16'(e_stb));
    check("active",    16'(active),    16'(e_active));
`ifdef SERIALTOPAR_BYTECNT_EN
    check("byte_count", byte_count, 16'(e_cnt));
`endif
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(v[i]);
  endtask

  task automatic send_rand_bits(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)));
  endtask

  function automatic logic [7:0] rand_payload();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    if (v == BC) v = 8'h3C;
    return v;
  endfunction

  // Assert reset between edges, confirm outputs clear at once, then release.
  task automatic apply_reset();
    @(posedge clk_8f);
    #3 reset = 1'b1;
    #1;
    check("rst_data_out",  16'(data_out),  16'h0000);
    check("rst_valid_out", 16'(valid_out), 16'h0000);
    check("rst_byte_stb",  16'(byte_stb),  16'h0000);
    check("rst_active",    16'(active),    16'h0000);
`ifdef SERIALTOPAR_BYTECNT_EN
    check("rst_byte_count", byte_count, 16'h0000);
`endif
    model_reset();
    repeat (2) @(posedge clk_8f);
    #2 reset = 1'b0;
  endtask

  // Directed scenarios, applied in sequence.
  initial begin
    model_reset();
    // Power-up reset.
    apply_reset();

    // Lock on a clean idle stream, then 12, 34 and random payload.
    repeat (6) send_byte(BC);
    send_byte(8'h12);
    send_byte(8'h34);
    for (int i = 0; i < 6; i++) send_byte(rand_payload());

    // Reset asserted in the middle of a byte while locked.
    send_rand_bits(3);
    apply_reset();
    check("post_rst_active", 16'(active), 16'h0000);

    // False lock: comma followed by a non-comma in ALIGN, then a clean relock.
    send_byte(BC);
    send_byte(8'h55);
    check("false_lock_active", 16'(active), 16'h0000);
    repeat (5) send_byte(BC);
    for (int i = 0; i < 4; i++) send_byte(rand_payload());

    // Bit slip: 3 junk bits ahead of commas, then FF, BC, 00 idle-gap pattern.
    apply_reset();
    send_rand_bits(3);
    repeat (6) send_byte(BC);
    send_byte(8'hFF);
    send_byte(BC);
    send_byte(8'h00);
    send_byte(rand_payload());

    // Five payload bytes interleaved with three commas after a fresh lock.
    apply_reset();
    repeat (5) send_byte(BC);
    send_byte(rand_payload()); send_byte(BC);
    send_byte(rand_payload()); send_byte(BC);
    send_byte(rand_payload()); send_byte(BC);
    send_byte(rand_payload());
    send_byte(rand_payload());
`ifdef SERIALTOPAR_BYTECNT_EN
    check("byte_count_five", byte_count, 16'd5);
`endif

    // Random junk followed by idle and random payload (mixed commas allowed).
    apply_reset();
    send_rand_bits(37);
    repeat (6) send_byte(BC);
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) send_byte(BC);
      else send_byte(rand_payload());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serialtopar.md
# serialtopar

Serial-to-parallel receiver for the PHY lane: recovers bytes from the MSB-first serial stream produced by the lane's parallel-to-serial transmitter. Both blocks run on the 8x bit clock. The receiver hunts for the idle comma (8'hBC) to find byte alignment, declares lock after a run of consecutive aligned commas, then delivers one byte per 8 bit-clock cycles with a valid flag. Idle commas are reported as invalid bytes. It sits between the lane's serial input and the byte-striping/unstriping logic.

## Interface
- COMMA, 8'hBC, idle/alignment character; never carried as payload
- BC_LOCK, 4, consecutive aligned commas required to reach ACTIVE; legal range 1..15
- clk_8f  input  1  bit clock; all logic on its rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- data_in  input  1  serial bit, MSB first, sampled every clk_8f edge
- data_out  output  8  last completed byte in ACTIVE; held between strobes
- valid_out  output  1  1 when data_out is payload (byte != COMMA); updated with byte_stb
- byte_stb  output  1  one-cycle pulse on each byte boundary in ACTIVE
- active  output  1  1 while in ACTIVE (lane locked)

## Operation
- Shift register: every edge, shift_q <= {shift_q[6:0], data_in}. Define nxt = {shift_q[6:0], data_in}.
- Bit counter cnt[2:0]: runs in ALIGN and ACTIVE, +1 per edge, wraps 7->0. A byte boundary is an edge with cnt==7; nxt is the completed byte.
- HUNT (reset state): compare nxt to COMMA every edge. On match: cnt<=0, bc_cnt<=1 (or go straight to ACTIVE if BC_LOCK==1), state ALIGN.
- ALIGN, on boundary:
  - nxt==COMMA: bc_cnt+1; when the count reaches BC_LOCK -> ACTIVE.
  - Otherwise -> HUNT, bc_cnt<=0.
  - No outputs change in ALIGN.
- ACTIVE, on boundary: data_out<=nxt, valid_out<=(nxt!=COMMA), byte_stb<=1. On every other edge byte_stb<=0, and data_out/valid_out hold.
- ACTIVE exits only on reset. There is no comma-based loss-of-sync detection; a payload byte equal to COMMA is a protocol violation and is reported as valid_out=0.
- active is a registered copy of (state==ACTIVE).
- bc_cnt is 4 bits and saturates at BC_LOCK.

## Timing
- Reset values: data_out=8'h00, valid_out=0, byte_stb=0, active=0, shift_q=0, cnt=0, bc_cnt=0, state HUNT. Outputs go low asynchronously on reset assertion.
- Latency: data_out, valid_out and byte_stb update on the same edge that samples the byte's LSB. A byte is visible from that edge until the next boundary, 8 cycles later.
- Lock time from a clean idle stream: the first comma matches in HUNT on edge E0. ACTIVE and active=1 are reached on edge E0 + 8*(BC_LOCK-1), which is E0+24 at the default.
- First byte_stb comes at the first boundary after entering ACTIVE, 8 edges later.
- The first strobed byte is the byte after the lock comma.
- Comma appearing misaligned during ALIGN (non-COMMA at the boundary): back to HUNT on that edge. Re-hunting starts on the next edge.
- Reset deasserted mid-byte: the block starts over in HUNT with cleared shift_q. Any prior alignment is discarded.

## Configuration
- SERIALTOPAR_BYTECNT_EN defined: adds output byte_count[15:0] (reset 0). It increments on each boundary in ACTIVE where valid_out becomes 1, saturates at 16'hFFFF, and clears only on reset.
- SERIALTOPAR_BYTECNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset: assert reset mid-stream -> all outputs 0 immediately; active=0 until a new lock.
- Lock: idle stream of 8'hBC, then payload 8'h12, 8'h34 -> active rises 24 edges after the first comma match. Next strobes give (BC, valid 0), ..., then (12, valid 1), (34, valid 1), 8 cycles apart.
- False lock: 8'hBC then 8'h55 while in ALIGN -> return to HUNT, active stays 0. Relock after 4 clean commas.
- Bit slip: the stream begins 3 bits offset (3 junk bits then commas) -> lock is still reached, with data_out aligned to the comma boundary.
- Idle gaps in ACTIVE: payload FF, BC, 00 -> valid_out 1, 0, 1. data_out is FF, BC, 00, and byte_stb pulses exactly one cycle each.
- With SERIALTOPAR_BYTECNT_EN: 5 payload bytes interleaved with 3 commas -> byte_count==5.
